// File: rtl/cpu_core.sv
// Multi-cycle 32-bit load/store core. Sequences FETCH/DECODE/EXEC/MEM/WB around an external
// combinational ALU and external instruction/data memories that have one-cycle read latency.
module cpu_core #(
    parameter int WIDTH_DATA = 32,
    parameter int AWIDTH     = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH_DATA-1:0] instruction,
    output logic [AWIDTH-1:0]     address_memory_inst,
    output logic                  read_inst_enable,
    output logic [WIDTH_DATA-1:0] memory_data_out,
    input  logic [WIDTH_DATA-1:0] memory_data_in,
    output logic                  read_data_enable,
    output logic                  write_data_enable,
    output logic [9:0]            address_memory_data,
    input  logic [WIDTH_DATA-1:0] result_alu,
    output logic [WIDTH_DATA-1:0] operand_a,
    output logic [WIDTH_DATA-1:0] operand_b,
    output logic [3:0]            op_ALU
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h01;
    localparam logic [5:0] OP_LW    = 6'h02;
    localparam logic [5:0] OP_SW    = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_JMP   = 6'h05;
    localparam logic [5:0] OP_HALT  = 6'h3f;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t                state_q, state_d;
    logic [AWIDTH-1:0]     pc_q, pc_d;
    logic [WIDTH_DATA-1:0] ir_q, ir_d;
    logic [WIDTH_DATA-1:0] aluout_q, aluout_d;
    logic [WIDTH_DATA-1:0] rs_val_q, rs_val_d;
    logic [WIDTH_DATA-1:0] rt_val_q, rt_val_d;
    logic [WIDTH_DATA-1:0] rf_q [32];
    logic [WIDTH_DATA-1:0] rf_d [32];

    logic                  wr_en;
    logic [4:0]            wr_idx;
    logic [WIDTH_DATA-1:0] wr_data;

    logic [5:0]            opcode;
    logic [4:0]            rs_idx, rt_idx, rd_idx, dec_rs, dec_rt;
    logic [3:0]            funct;
    logic [WIDTH_DATA-1:0] imm_sext;

    assign opcode   = ir_q[31:26];
    assign rs_idx   = ir_q[25:21];
    assign rt_idx   = ir_q[20:16];
    assign rd_idx   = ir_q[15:11];
    assign funct    = ir_q[3:0];
    assign imm_sext = {{(WIDTH_DATA-16){ir_q[15]}}, ir_q[15:0]};
    // Register operands are looked up from the word arriving in DECODE, before IR holds it.
    assign dec_rs   = instruction[25:21];
    assign dec_rt   = instruction[20:16];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= '0;
            ir_q     <= '0;
            aluout_q <= '0;
            rs_val_q <= '0;
            rt_val_q <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            aluout_q <= aluout_d;
            rs_val_q <= rs_val_d;
            rt_val_q <= rt_val_d;
            for (int i = 0; i < 32; i++) rf_q[i] <= rf_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                case (opcode)
                    OP_RTYPE, OP_ADDI: state_d = S_WB;
                    OP_LW, OP_SW:      state_d = S_MEM;
                    OP_HALT:           state_d = S_HALT;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEM:    state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        aluout_d = aluout_q;
        rs_val_d = rs_val_q;
        rt_val_d = rt_val_q;
        wr_en    = 1'b0;
        wr_idx   = '0;
        wr_data  = '0;
        for (int i = 0; i < 32; i++) rf_d[i] = rf_q[i];
        case (state_q)
            S_DECODE: begin
                ir_d     = instruction;
                rs_val_d = (dec_rs == '0) ? '0 : rf_q[dec_rs];
                rt_val_d = (dec_rt == '0) ? '0 : rf_q[dec_rt];
            end
            S_EXEC: begin
                aluout_d = result_alu;
                case (opcode)
                    OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_HALT: ;
                    // Branch offset is truncated to PC width so negative offsets wrap.
                    OP_BEQ:  pc_d = pc_q + AWIDTH'(1) + ((result_alu == '0) ? ir_q[AWIDTH-1:0] : '0);
                    OP_JMP:  pc_d = ir_q[AWIDTH-1:0];
                    default: pc_d = pc_q + AWIDTH'(1);
                endcase
            end
            S_MEM: begin
                if (opcode == OP_SW) pc_d = pc_q + AWIDTH'(1);
            end
            S_WB: begin
                pc_d  = pc_q + AWIDTH'(1);
                wr_en = 1'b1;
                case (opcode)
                    OP_LW: begin
                        wr_idx  = rt_idx;
                        wr_data = memory_data_in;
                    end
                    OP_RTYPE: begin
                        wr_idx  = rd_idx;
                        wr_data = aluout_q;
                    end
                    default: begin
                        wr_idx  = rt_idx;
                        wr_data = aluout_q;
                    end
                endcase
            end
            default: ;
        endcase
        if (wr_en && wr_idx != '0) rf_d[wr_idx] = wr_data;
    end

    // Every output is forced low while reset is high, so an aborted store never strobes.
    always_comb begin
        address_memory_inst = reset ? '0 : pc_q;
        read_inst_enable    = 1'b0;
        read_data_enable    = 1'b0;
        write_data_enable   = 1'b0;
        memory_data_out     = '0;
        address_memory_data = '0;
        operand_a           = '0;
        operand_b           = '0;
        op_ALU              = '0;
        if (!reset) begin
            case (state_q)
                S_FETCH: read_inst_enable = 1'b1;
                S_EXEC: begin
                    case (opcode)
                        OP_RTYPE: begin
                            operand_a = rs_val_q;
                            operand_b = rt_val_q;
                            op_ALU    = funct;
                        end
                        OP_BEQ: begin
                            operand_a = rs_val_q;
                            operand_b = rt_val_q;
                            op_ALU    = ALU_SUB;
                        end
                        OP_ADDI, OP_LW, OP_SW: begin
                            operand_a = rs_val_q;
                            operand_b = imm_sext;
                            op_ALU    = ALU_ADD;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    address_memory_data = aluout_q[9:0];
                    if (opcode == OP_LW) begin
                        read_data_enable = 1'b1;
                    end else begin
                        write_data_enable = 1'b1;
                        memory_data_out   = rt_val_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: instruction/data memories and ALU around the core, an instruction-level
// reference model producing an expected trace, and a monitor checking the trace cycle by cycle.
module tb_cpu_core;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [4:0]  address_memory_inst;
    logic        read_inst_enable;
    logic [31:0] memory_data_out;
    logic [31:0] memory_data_in;
    logic        read_data_enable;
    logic        write_data_enable;
    logic [9:0]  address_memory_data;
    logic [31:0] result_alu;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [3:0]  op_ALU;

    cpu_core dut (
        .clk                 (clk),
        .reset               (reset),
        .instruction         (instruction),
        .address_memory_inst (address_memory_inst),
        .read_inst_enable    (read_inst_enable),
        .memory_data_out     (memory_data_out),
        .memory_data_in      (memory_data_in),
        .read_data_enable    (read_data_enable),
        .write_data_enable   (write_data_enable),
        .address_memory_data (address_memory_data),
        .result_alu          (result_alu),
        .operand_a           (operand_a),
        .operand_b           (operand_b),
        .op_ALU              (op_ALU)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  pc;
        int          len;
        bit          has_alu;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        bit          is_ld;
        bit          is_st;
        bit          halt;
        logic [9:0]  maddr;
        logic [31:0] sdata;
    } rec_t;

    rec_t        exp_q[$];
    logic [31:0] imem [32];
    logic [31:0] dmem [1024];
    int          checks = 0;
    int          passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    return a << b[4:0];
            4'd7:    return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [3:0] fn);
        return {6'h00, rs, rt, rd, 7'd0, fn};
    endfunction

    // ---------------- environment: ALU and memories ----------------
    always_comb result_alu = alu_f(operand_a, operand_b, op_ALU);

    logic       pend_i = 1'b0;
    logic       pend_d = 1'b0;
    logic [4:0] pend_ia;
    logic [9:0] pend_da;
    always @(negedge clk) begin
        instruction    = pend_i ? imem[pend_ia] : $urandom;
        memory_data_in = pend_d ? dmem[pend_da] : $urandom;
        pend_i  = read_inst_enable;
        pend_ia = address_memory_inst;
        pend_d  = read_data_enable;
        pend_da = address_memory_data;
        if (write_data_enable) dmem[address_memory_data] = memory_data_out;
    end

    // ---------------- reference model ----------------
    task automatic build_trace(input int max_steps);
        logic [31:0] r [32];
        logic [31:0] md [1024];
        logic [4:0]  pc;
        logic [31:0] ins, simm, ea;
        logic [4:0]  rs, rt, rd;
        rec_t        e;
        for (int i = 0; i < 32; i++) r[i] = '0;
        md = dmem;
        pc = '0;
        for (int s = 0; s < max_steps; s++) begin
            ins  = imem[pc];
            rs   = ins[25:21];
            rt   = ins[20:16];
            rd   = ins[15:11];
            simm = {{16{ins[15]}}, ins[15:0]};
            e    = '{default: 0};
            e.pc = pc;
            case (ins[31:26])
                6'h00: begin
                    e.has_alu = 1; e.a = r[rs]; e.b = r[rt]; e.op = ins[3:0]; e.len = 4;
                    r[rd] = alu_f(e.a, e.b, e.op);
                    pc = pc + 5'd1;
                end
                6'h01: begin
                    e.has_alu = 1; e.a = r[rs]; e.b = simm; e.op = 4'd0; e.len = 4;
                    r[rt] = e.a + e.b;
                    pc = pc + 5'd1;
                end
                6'h02, 6'h03: begin
                    e.has_alu = 1; e.a = r[rs]; e.b = simm; e.op = 4'd0; e.len = 4;
                    ea = e.a + e.b;
                    e.maddr = ea[9:0];
                    if (ins[31:26] == 6'h02) begin
                        e.is_ld = 1; e.len = 5;
                        r[rt] = md[e.maddr];
                    end else begin
                        e.is_st = 1; e.sdata = r[rt];
                        md[e.maddr] = r[rt];
                    end
                    pc = pc + 5'd1;
                end
                6'h04: begin
                    e.has_alu = 1; e.a = r[rs]; e.b = r[rt]; e.op = 4'd1; e.len = 3;
                    pc = (e.a == e.b) ? pc + 5'd1 + simm[4:0] : pc + 5'd1;
                end
                6'h05: begin
                    e.len = 3;
                    pc = ins[4:0];
                end
                6'h3f: begin
                    e.halt = 1; e.len = 3;
                end
                default: begin
                    e.len = 3;
                    pc = pc + 5'd1;
                end
            endcase
            r[0] = '0;
            exp_q.push_back(e);
            if (e.halt) break;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit   mon_en = 0;
    bit   have_cur, started;
    int   cyc;
    rec_t cur;
    always @(negedge clk) begin
        if (!mon_en) begin
            have_cur = 0;
            started  = 0;
            cyc      = 0;
        end else begin
            if (!started) begin
                started = 1;
                check("first_fetch", 32'(read_inst_enable), 32'd1);
            end
            if (have_cur) cyc++;
            if (read_inst_enable && !(have_cur && cur.halt)) begin
                if (have_cur) check("instr_cycles", 32'(cyc), 32'(cur.len));
                if (exp_q.size() > 0) begin
                    cur      = exp_q.pop_front();
                    have_cur = 1;
                    cyc      = 0;
                    check("fetch_addr", 32'(address_memory_inst), 32'(cur.pc));
                end else begin
                    have_cur = 0;
                end
            end
            if (have_cur) begin
                if (cyc == 2) begin
                    check("exec_operand_a", operand_a, cur.has_alu ? cur.a : 32'd0);
                    check("exec_operand_b", operand_b, cur.has_alu ? cur.b : 32'd0);
                    check("exec_op_alu", 32'(op_ALU), cur.has_alu ? 32'(cur.op) : 32'd0);
                end
                if (!cur.halt) begin
                    check("rd_strobe", 32'(read_data_enable), 32'(cur.is_ld && cyc == 3));
                    check("wr_strobe", 32'(write_data_enable), 32'(cur.is_st && cyc == 3));
                end else if (cyc >= 1) begin
                    check("halt_quiet", 32'({read_inst_enable, read_data_enable, write_data_enable}), 32'd0);
                end
                if (cyc == 3 && (cur.is_ld || cur.is_st))
                    check("mem_addr", 32'(address_memory_data), 32'(cur.maddr));
                if (cyc == 3 && cur.is_st)
                    check("store_data", memory_data_out, cur.sdata);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic rst_check();
        check("rst_inst_en", 32'(read_inst_enable), 32'd0);
        check("rst_rd_en", 32'(read_data_enable), 32'd0);
        check("rst_wr_en", 32'(write_data_enable), 32'd0);
        check("rst_inst_addr", 32'(address_memory_inst), 32'd0);
        check("rst_data_addr", 32'(address_memory_data), 32'd0);
        check("rst_data_out", memory_data_out, 32'd0);
        check("rst_operand_a", operand_a, 32'd0);
        check("rst_operand_b", operand_b, 32'd0);
        check("rst_op_alu", 32'(op_ALU), 32'd0);
    endtask

    // Leaves reset high just after the second sampled rising edge.
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset  = 1'b1;
        mon_en = 0;
        @(negedge clk);
        rst_check();
        @(posedge clk);
        @(negedge clk);
        rst_check();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int max_steps);
        int n;
        exp_q.delete();
        build_trace(max_steps);
        reset  = 1'b0;
        mon_en = 1;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("trace_drained", 32'(exp_q.size()), 32'd0);
        repeat (12) @(negedge clk);
        mon_en = 0;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 32; i++) imem[i] = 32'h4000_0000;
    endtask

    task automatic rand_prog();
        int k;
        for (int i = 0; i < 32; i++) begin
            k = $urandom_range(0, 11);
            case (k)
                0, 1, 2, 3: imem[i] = enc_r(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                            5'($urandom_range(0, 7)), 4'($urandom_range(0, 9)));
                4, 5: imem[i] = enc_i(6'h01, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                      16'($urandom_range(0, 40)) - 16'd20);
                6:  imem[i] = enc_i(6'h02, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom_range(0, 63)));
                7:  imem[i] = enc_i(6'h03, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom_range(0, 63)));
                8:  imem[i] = enc_i(6'h04, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                    16'($urandom_range(0, 6)) - 16'd3);
                9:  imem[i] = {6'h05, 26'($urandom_range(0, 31))};
                10: imem[i] = {6'($urandom_range(6, 62)), 26'($urandom)};
                default: imem[i] = ($urandom_range(0, 3) == 0) ? 32'hFC00_0000 : 32'h4000_0000;
            endcase
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        reset = 1'b1;
        for (int i = 0; i < 1024; i++) dmem[i] = $urandom;

        do_reset();
        fill_nop();
        imem[0]  = enc_i(6'h01, 5'd0, 5'd1, 16'd5);
        imem[1]  = enc_i(6'h01, 5'd0, 5'd2, 16'hFFFD);
        imem[2]  = enc_r(5'd1, 5'd2, 5'd3, 4'd0);
        imem[3]  = enc_i(6'h03, 5'd0, 5'd1, 16'd4);
        imem[4]  = enc_i(6'h02, 5'd0, 5'd4, 16'd4);
        imem[5]  = enc_i(6'h03, 5'd0, 5'd3, 16'd8);
        imem[6]  = enc_i(6'h03, 5'd0, 5'd4, 16'd9);
        imem[7]  = enc_i(6'h04, 5'd1, 5'd2, 16'd5);
        imem[8]  = enc_i(6'h01, 5'd0, 5'd0, 16'd7);
        imem[9]  = enc_r(5'd0, 5'd0, 5'd5, 4'd0);
        imem[10] = enc_i(6'h03, 5'd0, 5'd5, 16'd10);
        imem[11] = enc_r(5'd1, 5'd2, 5'd6, 4'd1);
        imem[12] = {6'h05, 26'd31};
        go(24);

        do_reset();
        fill_nop();
        imem[0] = enc_i(6'h01, 5'd0, 5'd1, 16'd9);
        imem[1] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
        go(8);

        do_reset();
        fill_nop();
        imem[0] = enc_i(6'h03, 5'd0, 5'd2, 16'd7);
        imem[1] = enc_i(6'h01, 5'd0, 5'd1, 16'd3);
        imem[2] = enc_i(6'h01, 5'd0, 5'd2, 16'd9);
        imem[3] = enc_i(6'h03, 5'd0, 5'd1, 16'd2);
        imem[4] = enc_i(6'h02, 5'd0, 5'd3, 16'd2);
        imem[5] = enc_i(6'h03, 5'd0, 5'd3, 16'd3);
        imem[6] = 32'hFC00_0000;
        go(40);

        // Abort the same program mid-load, then expect a clean restart with cleared registers.
        do_reset();
        reset = 1'b0;
        n = 0;
        @(negedge clk);
        while (!read_data_enable && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_load", 32'(read_data_enable), 32'd1);
        reset = 1'b1;
        #1;
        rst_check();
        @(posedge clk);
        @(negedge clk);
        rst_check();
        @(posedge clk);
        #1;
        go(40);

        for (int t = 0; t < 6; t++) begin
            do_reset();
            rand_prog();
            go(40);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
